// File: rtl/hit_life_manager.sv
// hit_life_manager: turns once-per-frame collision pulses into lives,
// a frame-counted invulnerability window with sprite blink, and game over.
// Ports: clk, reset (async, active high), startOfFrame, SingleHitPulse,
//        restart, bonus_pulse (only with HIT_LIFE_MANAGER_EXTRA_LIFE_EN),
//        lives[2:0], lifeLostPulse, invulnerable, spriteVisible, gameOver.
// Optional macro: HIT_LIFE_MANAGER_EXTRA_LIFE_EN enables bonus_pulse.
module hit_life_manager #(
  parameter int unsigned INIT_LIVES   = 3,
  parameter int unsigned INV_FRAMES   = 60,
  parameter int unsigned BLINK_FRAMES = 4,
  parameter int unsigned MAX_LIVES    = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       SingleHitPulse,
  input  logic       restart,
`ifdef HIT_LIFE_MANAGER_EXTRA_LIFE_EN
  input  logic       bonus_pulse,
`endif
  output logic [2:0] lives,
  output logic       lifeLostPulse,
  output logic       invulnerable,
  output logic       spriteVisible,
  output logic       gameOver
);

  typedef enum logic [1:0] {PLAY, INVULN, DEAD} state_t;

  localparam logic [2:0] INIT_L  = 3'(INIT_LIVES);
  localparam logic [7:0] INV_L   = 8'(INV_FRAMES);
  localparam logic [3:0] BLINK_L = 4'(BLINK_FRAMES);

  state_t     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [7:0] inv_cnt_q, inv_cnt_d;
  logic [3:0] blink_cnt_q, blink_cnt_d;
  logic       llp_q, llp_d;
  logic       inv_q, inv_d;
  logic       vis_q, vis_d;
  logic       go_q, go_d;

`ifdef HIT_LIFE_MANAGER_EXTRA_LIFE_EN
  localparam logic [2:0] MAX_L = 3'(MAX_LIVES);

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v < MAX_L) ? v + 3'd1 : v;
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    inv_cnt_d   = inv_cnt_q;
    blink_cnt_d = blink_cnt_q;
    llp_d       = 1'b0;
    inv_d       = inv_q;
    vis_d       = vis_q;
    go_d        = go_q;
    if (restart) begin
      state_d     = PLAY;
      lives_d     = INIT_L;
      inv_cnt_d   = '0;
      blink_cnt_d = '0;
      inv_d       = 1'b0;
      vis_d       = 1'b1;
      go_d        = 1'b0;
    end else begin
      case (state_q)
        PLAY: begin
          if (SingleHitPulse) begin
            llp_d = 1'b1;
            if (lives_q > 3'd1) begin
              state_d     = INVULN;
              lives_d     = lives_q - 3'd1;
              inv_cnt_d   = INV_L;
              blink_cnt_d = BLINK_L;
              inv_d       = 1'b1;
              vis_d       = 1'b0;
`ifdef HIT_LIFE_MANAGER_EXTRA_LIFE_EN
              // bonus applies to the post-hit count
              if (bonus_pulse) lives_d = sat_inc(lives_q - 3'd1);
`endif
            end else begin
              state_d = DEAD;
              lives_d = '0;
              inv_d   = 1'b0;
              vis_d   = 1'b1;
              go_d    = 1'b1;
            end
          end
`ifdef HIT_LIFE_MANAGER_EXTRA_LIFE_EN
          else if (bonus_pulse) lives_d = sat_inc(lives_q);
`endif
        end
        INVULN: begin
          if (startOfFrame) begin
            inv_cnt_d = inv_cnt_q - 8'd1;
            if (inv_cnt_q == 8'd1) begin
              state_d     = PLAY;
              blink_cnt_d = '0;
              inv_d       = 1'b0;
              vis_d       = 1'b1;
            end else if (blink_cnt_q == 4'd1) begin
              blink_cnt_d = BLINK_L;
              vis_d       = ~vis_q;
            end else begin
              blink_cnt_d = blink_cnt_q - 4'd1;
            end
          end
`ifdef HIT_LIFE_MANAGER_EXTRA_LIFE_EN
          if (bonus_pulse) lives_d = sat_inc(lives_q);
`endif
        end
        DEAD: begin
          lives_d = '0;
          go_d    = 1'b1;
          vis_d   = 1'b1;
        end
        default: state_d = PLAY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PLAY;
      lives_q     <= INIT_L;
      inv_cnt_q   <= '0;
      blink_cnt_q <= '0;
      llp_q       <= 1'b0;
      inv_q       <= 1'b0;
      vis_q       <= 1'b1;
      go_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      inv_cnt_q   <= inv_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      llp_q       <= llp_d;
      inv_q       <= inv_d;
      vis_q       <= vis_d;
      go_q        <= go_d;
    end
  end

  assign lives         = lives_q;
  assign lifeLostPulse = llp_q;
  assign invulnerable  = inv_q;
  assign spriteVisible = vis_q;
  assign gameOver      = go_q;

endmodule

// File: tb/tb_hit_life_manager.sv
module tb_hit_life_manager;

  logic       clk = 1'b0;
  logic       reset;
  logic       startOfFrame;
  logic       SingleHitPulse;
  logic       restart;
  logic       bonus_pulse;
  logic [2:0] lives;
  logic       lifeLostPulse;
  logic       invulnerable;
  logic       spriteVisible;
  logic       gameOver;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [6:0] v;   // {lives, lifeLostPulse, invulnerable, spriteVisible, gameOver}
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  hit_life_manager #(
    .INIT_LIVES(3), .INV_FRAMES(60), .BLINK_FRAMES(4), .MAX_LIVES(7)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .startOfFrame  (startOfFrame),
    .SingleHitPulse(SingleHitPulse),
    .restart       (restart),
`ifdef HIT_LIFE_MANAGER_EXTRA_LIFE_EN
    .bonus_pulse   (bonus_pulse),
`endif
    .lives         (lives),
    .lifeLostPulse (lifeLostPulse),
    .invulnerable  (invulnerable),
    .spriteVisible (spriteVisible),
    .gameOver      (gameOver)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [6:0] exp_v);
    logic [6:0] act;
    act = {lives, lifeLostPulse, invulnerable, spriteVisible, gameOver};
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got lives=%0d llp=%b inv=%b vis=%b go=%b, want lives=%0d llp=%b inv=%b vis=%b go=%b",
               nm, act[6:4], act[3], act[2], act[1], act[0],
               exp_v[6:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
    end
  endtask

  // Monitor: outputs are registered, so each pushed expectation is due
  // just after the following rising edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check(mon_e.nm, mon_e.v);
    end
  end

  task automatic step(input bit h, input bit s, input bit r, input bit b,
                      input logic [2:0] l, input bit llp, input bit inv,
                      input bit vis, input bit go, input string nm);
    exp_t e;
    @(negedge clk);
    SingleHitPulse = h;
    startOfFrame   = s;
    restart        = r;
    bonus_pulse    = b;
    e.v  = {l, llp, inv, vis, go};
    e.nm = nm;
    q.push_back(e);
  endtask

  task automatic idle(input logic [2:0] l, input bit llp, input bit inv,
                      input bit vis, input bit go, input string nm);
    step(0, 0, 0, 0, l, llp, inv, vis, go, nm);
  endtask

  // 60 frame pulses after a non-fatal hit: sprite starts hidden and toggles
  // after every 4th frame; window closes right after the 60th.
  task automatic frames(input logic [2:0] l, input int nh, input bit hit_exit);
    bit h, last, vis;
    for (int k = 1; k <= 60; k++) begin
      h    = (k <= nh) || (hit_exit && k == 60);
      last = (k == 60);
      vis  = last ? 1'b1 : (((k / 4) % 2) == 1);
      step(h, 1, 0, 0, l, 0, !last, vis, 0, last ? "frame_exit" : "frame");
      idle(l, 0, !last, vis, 0, "frame_gap");
    end
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; SingleHitPulse = 1'b0;
    restart = 1'b0; bonus_pulse = 1'b0;

    idle(3, 0, 0, 1, 0, "reset");
    reset = 1'b0;
    idle(3, 0, 0, 1, 0, "post_reset");

    // hit together with a frame pulse: hit wins, full 60-frame window
    step(1, 1, 0, 0, 2, 1, 1, 0, 0, "hit_sof");
    idle(2, 0, 1, 0, 0, "pulse_drop");
    frames(2, 10, 0);
    idle(2, 0, 0, 1, 0, "play_again");

    step(1, 0, 0, 0, 1, 1, 1, 0, 0, "hit2");
    frames(1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 1, 1, "fatal_hit");
    idle(0, 0, 0, 1, 1, "dead");
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, "dead_hit");
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, "dead_hit_sof");
    step(0, 0, 1, 0, 3, 0, 0, 1, 0, "restart_dead");

    step(1, 0, 0, 0, 2, 1, 1, 0, 0, "hit_a");
    frames(2, 0, 0);
    step(1, 0, 0, 0, 1, 1, 1, 0, 0, "hit_b");
    frames(1, 0, 0);
    step(1, 0, 1, 0, 3, 0, 0, 1, 0, "hit_restart");
    idle(3, 0, 0, 1, 0, "after_hit_restart");

    // hit on the exit clock is ignored
    step(1, 0, 0, 0, 2, 1, 1, 0, 0, "hit_c");
    frames(2, 0, 1);
    idle(2, 0, 0, 1, 0, "after_exit_hit");

    step(1, 0, 0, 0, 1, 1, 1, 0, 0, "hit_d");
    step(0, 1, 0, 0, 1, 0, 1, 0, 0, "inv_frame");
    step(0, 0, 1, 0, 3, 0, 0, 1, 0, "restart_inv");

    // asynchronous reset inside the window
    step(1, 0, 0, 0, 2, 1, 1, 0, 0, "hit_e");
    step(0, 1, 0, 0, 2, 0, 1, 0, 0, "inv_frame2");
    idle(2, 0, 1, 0, 0, "inv_hold");
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset", {3'd3, 1'b0, 1'b0, 1'b1, 1'b0});
    idle(3, 0, 0, 1, 0, "reset_held");
    reset = 1'b0;
    idle(3, 0, 0, 1, 0, "reset_release");

`ifdef HIT_LIFE_MANAGER_EXTRA_LIFE_EN
    step(0, 0, 0, 1, 4, 0, 0, 1, 0, "bonus1");
    step(0, 0, 0, 1, 5, 0, 0, 1, 0, "bonus2");
    step(0, 0, 0, 1, 6, 0, 0, 1, 0, "bonus3");
    step(0, 0, 0, 1, 7, 0, 0, 1, 0, "bonus4");
    step(0, 0, 0, 1, 7, 0, 0, 1, 0, "bonus_sat");
    step(1, 0, 0, 1, 7, 1, 1, 0, 0, "bonus_hit");
    idle(7, 0, 1, 0, 0, "bonus_hit_hold");
`endif

    idle(0, 0, 0, 0, 0, "unused");
    void'(q.pop_back());

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
